bin_to_gray: RTL and testbench



---
 rtl/bin_to_gray.sv | 65 ++++++
 tb/tb_bin_to_gray.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_gray.sv
// Binary-to-Gray converter: combinational encode plus a valid-qualified registered
// stage with round-trip decode and a single-bit-step flag against the previous capture.
module bin_to_gray #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    input  logic             in_valid,
    output logic [WIDTH-1:0] gray_q,
    output logic [WIDTH-1:0] bin_rt,
    output logic             out_valid,
    output logic             step_ok
);

    logic [WIDTH-1:0] code_d;
    logic [WIDTH-1:0] code_q;
    logic [WIDTH-1:0] diff;
    logic             one_bit;
    logic             step_d;
    logic             step_q;
    logic             valid_q;
    logic             have_prev_q;
    logic             acc;

    assign code_d = bin ^ (bin >> 1);
    assign gray   = code_d;

    // Running XOR from the MSB down undoes the encode without a self-referencing vector.
    always_comb begin
        bin_rt = '0;
        acc    = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc       = acc ^ code_q[i];
            bin_rt[i] = acc;
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign diff    = code_d ^ code_q;
    assign one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    assign step_d  = have_prev_q & one_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q      <= '0;
            valid_q     <= 1'b0;
            step_q      <= 1'b0;
            have_prev_q <= 1'b0;
        end else if (in_valid) begin
            code_q      <= code_d;
            valid_q     <= 1'b1;
            step_q      <= step_d;
            have_prev_q <= 1'b1;
        end else begin
            valid_q     <= 1'b0;
        end
    end

    assign gray_q    = code_q;
    assign out_valid = valid_q;
    assign step_ok   = step_q;

endmodule

// File: tb/tb_bin_to_gray.sv
// Self-checking bench for bin_to_gray at WIDTH 4, 1 and 8: vector table, directed
// sequences and randomized traffic against an arithmetic reference model.
module tb_bin_to_gray;

    logic clk;
    logic rst_n;

    logic [3:0] b4, g4, gq4, rt4;
    logic       v4, ov4, so4;
    logic       b1, g1, gq1, rt1;
    logic       v1, ov1, so1;
    logic [7:0] b8, g8, gq8, rt8;
    logic       v8, ov8, so8;

    int n_vec;
    int n_err;

    // Reference state for the WIDTH=4 instance
    logic [3:0] m_prev;
    logic [3:0] m_rtbin;
    logic       m_have;
    logic       m_step;
    logic       m_ov;

    typedef struct {
        logic [3:0] b;
        logic [3:0] g;
    } vec_t;
    vec_t tbl[8];

    bin_to_gray #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .bin(b4), .gray(g4), .in_valid(v4),
        .gray_q(gq4), .bin_rt(rt4), .out_valid(ov4), .step_ok(so4)
    );
    bin_to_gray #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .bin(b1), .gray(g1), .in_valid(v1),
        .gray_q(gq1), .bin_rt(rt1), .out_valid(ov1), .step_ok(so1)
    );
    bin_to_gray #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .bin(b8), .gray(g8), .in_valid(v8),
        .gray_q(gq8), .bin_rt(rt8), .out_valid(ov8), .step_ok(so8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] gref(input logic [31:0] b, input int w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return ((b & mask) ^ ((b & mask) >> 1)) & mask;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_rtbin = '0;
        m_have  = 1'b0;
        m_step  = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic check_regs_zero(input string tag);
        chk({tag, " gray_q4"}, 32'(gq4), 32'd0);
        chk({tag, " bin_rt4"}, 32'(rt4), 32'd0);
        chk({tag, " out_valid4"}, 32'(ov4), 32'd0);
        chk({tag, " step_ok4"}, 32'(so4), 32'd0);
        chk({tag, " gray_q8"}, 32'(gq8), 32'd0);
        chk({tag, " gray_q1"}, 32'(gq1), 32'd0);
        chk({tag, " out_valid8"}, 32'(ov8), 32'd0);
    endtask

    // One cycle on the WIDTH=4 instance, checked against the reference model.
    task automatic step4(input logic [3:0] b, input logic v);
        logic [3:0] ng;
        @(negedge clk);
        b4 = b;
        v4 = v;
        #1;
        chk("comb gray4", 32'(g4), gref(32'(b), 4));
        @(posedge clk);
        #1;
        if (v) begin
            ng      = 4'(gref(32'(b), 4));
            m_step  = m_have && ($countones(ng ^ m_prev) == 1);
            m_prev  = ng;
            m_rtbin = b;
            m_have  = 1'b1;
            m_ov    = 1'b1;
        end else begin
            m_ov = 1'b0;
        end
        chk("gray_q4", 32'(gq4), 32'(m_prev));
        chk("bin_rt4", 32'(rt4), 32'(m_rtbin));
        chk("out_valid4", 32'(ov4), 32'(m_ov));
        chk("step_ok4", 32'(so4), 32'(m_step));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_regs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        b4 = '0; v4 = 1'b0;
        b1 = 1'b0; v1 = 1'b0;
        b8 = '0; v8 = 1'b0;

        tbl[0] = '{b: 4'b0000, g: 4'b0000};
        tbl[1] = '{b: 4'b0101, g: 4'b0111};
        tbl[2] = '{b: 4'b1010, g: 4'b1111};
        tbl[3] = '{b: 4'b1111, g: 4'b1000};
        tbl[4] = '{b: 4'b0110, g: 4'b0101};
        tbl[5] = '{b: 4'b0011, g: 4'b0010};
        tbl[6] = '{b: 4'b1000, g: 4'b1100};
        tbl[7] = '{b: 4'b0001, g: 4'b0001};

        #3 check_regs_zero("init");

        // Combinational path is exercised while reset is still asserted.
        for (int i = 0; i < 8; i++) begin
            b4 = tbl[i].b;
            #1 chk("table gray4", 32'(g4), 32'(tbl[i].g));
        end
        for (int i = 0; i < 16; i++) begin
            b4 = 4'(i);
            #1 chk("sweep gray4", 32'(g4), gref(32'(i), 4));
        end
        for (int i = 0; i < 2; i++) begin
            b1 = 1'(i);
            #1 chk("sweep gray1", 32'(g1), 32'(i));
        end
        for (int i = 0; i < 256; i++) begin
            b8 = 8'(i);
            #1 chk("sweep gray8", 32'(g8), gref(32'(i), 8));
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Single capture then idle
        step4(4'b0110, 1'b1);
        chk("dir gray_q 0110", 32'(gq4), 32'h5);
        chk("dir first step_ok", 32'(so4), 32'd0);
        step4(4'b1111, 1'b0);
        chk("dir idle out_valid", 32'(ov4), 32'd0);
        chk("dir idle gray_q held", 32'(gq4), 32'h5);

        // Counting sequence with wrap, from a fresh reset
        pulse_reset();
        for (int i = 0; i <= 16; i++) begin
            step4(4'(i % 16), 1'b1);
            chk("count step_ok", 32'(so4), (i == 0) ? 32'd0 : 32'd1);
        end

        // Two-bit step and repeated value
        step4(4'b0011, 1'b1);
        step4(4'b0101, 1'b1);
        chk("two-bit step_ok", 32'(so4), 32'd0);
        step4(4'b0101, 1'b1);
        chk("repeat step_ok", 32'(so4), 32'd0);

        // Reset with a capture in flight
        @(negedge clk);
        b4 = 4'b1001;
        v4 = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_regs_zero("midstream");
        @(posedge clk);
        #1 check_regs_zero("held in reset");
        @(negedge clk);
        rst_n = 1'b1;
        step4(4'b0001, 1'b1);
        chk("post-reset gray_q", 32'(gq4), 32'h1);
        chk("post-reset step_ok", 32'(so4), 32'd0);
        step4(4'b0000, 1'b0);

        // WIDTH=8 exhaustive captures, counting from a fresh history
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            b8 = 8'(i);
            v8 = 1'b1;
            #1 chk("w8 comb gray", 32'(g8), gref(32'(i), 8));
            @(posedge clk);
            #1;
            chk("w8 gray_q", 32'(gq8), gref(32'(i), 8));
            chk("w8 bin_rt", 32'(rt8), 32'(i));
            chk("w8 step_ok", 32'(so8), (i == 0) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        v8 = 1'b0;

        // WIDTH=1 toggles and a repeat
        begin
            logic [4:0] seq;
            logic [4:0] exp_step;
            seq      = 5'b11010;
            exp_step = 5'b01110;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                b1 = seq[i];
                v1 = 1'b1;
                #1 chk("w1 comb gray", 32'(g1), 32'(seq[i]));
                @(posedge clk);
                #1;
                chk("w1 gray_q", 32'(gq1), 32'(seq[i]));
                chk("w1 bin_rt", 32'(rt1), 32'(seq[i]));
                chk("w1 step_ok", 32'(so1), 32'(exp_step[i]));
                chk("w1 out_valid", 32'(ov1), 32'd1);
            end
            @(negedge clk);
            v1 = 1'b0;
        end

        // Randomized traffic on WIDTH=4, biased towards small steps so step_ok toggles
        for (int i = 0; i < 300; i++) begin
            logic [3:0] nb;
            if ($urandom_range(0, 2) == 0)
                nb = 4'($urandom_range(0, 15));
            else
                nb = m_rtbin + 4'($urandom_range(0, 2)) - 4'd1;
            step4(nb, 1'($urandom_range(0, 3) != 0));
            if (i == 150) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
